array_window_buf: RTL and testbench

//  Parametrised circular buffer whose storage and I/O are unpacked arrays.
//  It supports single-entry push/pop, whole-array load and broadcast fill,
//  and exposes a WIN-entry read window as an unpacked array.

---
 rtl/array_window_buf.sv | 158 +++++++++++++++
 tb/tb_array_window_buf.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_window_buf.sv
// -----------------------------------------------------------------------------
// array_window_buf
//
// Circular buffer whose storage and I/O are unpacked arrays. Supports
// single-entry push/pop, whole-array load, broadcast fill, and exposes a
// WIN-entry read window that starts at the read pointer.
//
// Parameters
//   WIDTH  bits per entry
//   DEPTH  number of entries (power of 2, >= 2)
//   WIN    window length (1 <= WIN <= DEPTH)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   push request
//   in_ready   push can be accepted this cycle (!full || pop_ok)
//   in_data    entry to push
//   pop        pop request, ignored when empty
//   load       replace the whole buffer with load_data (slot i <= element i)
//   load_data  unpacked [DEPTH-1:0] array of entries
//   fill       write fill_data into every slot
//   fill_data  broadcast value
//   head_data  entry at the read pointer, 0 when empty
//   win_data   unpacked [WIN-1:0]; win_data[i] = mem[(rd_ptr+i) mod DEPTH]
//   win_valid  count >= WIN
//   count      occupancy 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//
// Priority each cycle: load > fill > push/pop.
// -----------------------------------------------------------------------------
module array_window_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int WIN   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     pop,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_data [DEPTH-1:0],
    input  logic                     fill,
    input  logic [WIDTH-1:0]         fill_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         win_data [WIN-1:0],
    output logic                     win_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Registered state
    logic [WIDTH-1:0] mem_q [DEPTH-1:0];
    logic [WIDTH-1:0] mem_d [DEPTH-1:0];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Per-cycle handshake qualifiers
    logic pop_ok;
    logic push_ok;
    logic full_s;
    logic empty_s;
    logic in_ready_s;

    // Occupancy flags and handshake qualification
    always_comb begin
        empty_s    = (count_q == {CW{1'b0}});
        full_s     = (count_q == CW'(DEPTH));
        pop_ok     = pop && !empty_s;
        // A pop in the same cycle frees a slot, so a full buffer can still accept.
        in_ready_s = !full_s || pop_ok;
        push_ok    = in_valid && in_ready_s && !load && !fill;
    end

    // Next-state computation: load wins over fill, fill wins over push/pop
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (load) begin
            mem_d    = load_data;
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = CW'(DEPTH);
        end else if (fill) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = fill_data;
            end
            count_d = CW'(DEPTH);
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = in_data;
                // DEPTH is a power of 2, so the natural PW-bit wrap is mod DEPTH.
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Output decode from registered state; only in_ready also sees the pop input
    always_comb begin
        full      = full_s;
        empty     = empty_s;
        in_ready  = in_ready_s;
        count     = count_q;
        win_valid = (count_q >= CW'(WIN));
        if (empty_s) begin
            head_data = {WIDTH{1'b0}};
        end else begin
            head_data = mem_q[rd_ptr_q];
        end
        // Window entries beyond count show stale contents; win_valid qualifies them.
        for (int i = 0; i < WIN; i++) begin
            win_data[i] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

endmodule

// File: tb/tb_array_window_buf.sv
module tb_array_window_buf;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int WIN   = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             pop;
    logic             load;
    logic [WIDTH-1:0] load_data [DEPTH-1:0];
    logic             fill;
    logic [WIDTH-1:0] fill_data;
    logic [WIDTH-1:0] head_data;
    logic [WIDTH-1:0] win_data [WIN-1:0];
    logic             win_valid;
    logic [2:0]       count;
    logic             full;
    logic             empty;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: slot contents, read/write positions and occupancy
    int m_mem [DEPTH];
    int m_rd;
    int m_wr;
    int m_cnt;

    array_window_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WIN(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .pop(pop), .load(load), .load_data(load_data),
        .fill(fill), .fill_data(fill_data), .head_data(head_data),
        .win_data(win_data), .win_valid(win_valid), .count(count),
        .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_rd = 0; m_wr = 0; m_cnt = 0;
    endfunction

    function automatic logic exp_ready();
        return (m_cnt < DEPTH) || (pop && m_cnt > 0);
    endfunction

    // Apply the current inputs to the model as the coming clock edge will
    function automatic void model_clock();
        bit pop_ok, push_ok;
        if (load) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = int'(load_data[i]);
            m_rd = 0; m_wr = 0; m_cnt = DEPTH;
        end else if (fill) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = int'(fill_data);
            m_cnt = DEPTH;
        end else begin
            pop_ok  = pop && (m_cnt > 0);
            push_ok = in_valid && ((m_cnt < DEPTH) || pop_ok);
            if (push_ok) begin
                m_mem[m_wr] = int'(in_data);
                m_wr = (m_wr + 1) % DEPTH;
            end
            if (pop_ok) m_rd = (m_rd + 1) % DEPTH;
            m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
        end
    endfunction

    function automatic logic [17:0] exp_snap();
        logic [3:0] h, w0, w1;
        h  = (m_cnt == 0) ? 4'd0 : 4'(m_mem[m_rd]);
        w0 = 4'(m_mem[m_rd % DEPTH]);
        w1 = 4'(m_mem[(m_rd + 1) % DEPTH]);
        return {h, w1, w0, (m_cnt >= WIN), 3'(m_cnt), (m_cnt == DEPTH), (m_cnt == 0)};
    endfunction

    function automatic logic [17:0] act_snap();
        return {head_data, win_data[1], win_data[0], win_valid, count, full, empty};
    endfunction

    task automatic clear_inputs();
        in_valid = 1'b0; in_data = 4'd0; pop = 1'b0; load = 1'b0;
        fill = 1'b0; fill_data = 4'd0;
        for (int i = 0; i < DEPTH; i++) load_data[i] = 4'd0;
    endtask

    // One clock: model follows the inputs, then settle just after the edge
    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [3:0] v);
        in_valid = 1'b1; in_data = v;
        cycle();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if (act_snap() !== exp_snap()) $display("FAIL reset_state: got %h expected %h", act_snap(), exp_snap());
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || win_data[0] !== 4'd0 || win_data[1] !== 4'd0)
            $display("FAIL reset_flags: in_ready=%b empty=%b full=%b win0=%h win1=%h required 1 1 0 0 0", in_ready, empty, full, win_data[0], win_data[1]);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_to_full();
        for (int k = 1; k <= 4; k++) push(4'(k));
        n_checks++;
        if (act_snap() !== exp_snap()) $display("FAIL full_model: got %h expected %h", act_snap(), exp_snap());
        else n_pass++;
        n_checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4 || head_data !== 4'd1 ||
            win_data[1] !== 4'd2 || win_data[0] !== 4'd1 || win_valid !== 1'b1)
            $display("FAIL full_const: full=%b in_ready=%b count=%0d head=%h win=%h,%h wv=%b required 1 0 4 1 2,1 1",
                     full, in_ready, count, head_data, win_data[1], win_data[0], win_valid);
        else n_pass++;
    endtask

    task automatic test_pop_push_wrap();
        logic [3:0] order [4];
        order[0] = 4'd2; order[1] = 4'd3; order[2] = 4'd4; order[3] = 4'd5;
        pop = 1'b1; in_valid = 1'b1; in_data = 4'd5;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL full_pop_ready: got %b required 1", in_ready);
        else n_pass++;
        cycle();
        clear_inputs();
        n_checks++;
        if (count !== 3'd4 || head_data !== 4'd2 || win_data[1] !== 4'd3 || win_data[0] !== 4'd2)
            $display("FAIL pop_push_full: count=%0d head=%h win=%h,%h required 4 2 3,2", count, head_data, win_data[1], win_data[0]);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (head_data !== order[k]) $display("FAIL pop_order%0d: got %h required %h", k, head_data, order[k]);
            else n_pass++;
            pop = 1'b1;
            cycle();
            clear_inputs();
        end
        n_checks++;
        if (empty !== 1'b1 || head_data !== 4'd0 || act_snap() !== exp_snap())
            $display("FAIL drained: empty=%b head=%h snap=%h required 1 0 %h", empty, head_data, act_snap(), exp_snap());
        else n_pass++;
        // Write pointer wrapped to slot 1: a new entry appears right at the head.
        push(4'd6);
        n_checks++;
        if (head_data !== 4'd6 || act_snap() !== exp_snap())
            $display("FAIL wrap_push: head=%h snap=%h required 6 %h", head_data, act_snap(), exp_snap());
        else n_pass++;
    endtask

    task automatic test_load();
        load = 1'b1; fill = 1'b1; fill_data = 4'd3; pop = 1'b1;
        in_valid = 1'b1; in_data = 4'hF;
        load_data = '{4'hD, 4'hC, 4'hB, 4'hA};
        cycle();
        clear_inputs();
        n_checks++;
        if (count !== 3'd4 || head_data !== 4'hA || win_data[1] !== 4'hB || win_data[0] !== 4'hA)
            $display("FAIL load: count=%0d head=%h win=%h,%h required 4 A B,A", count, head_data, win_data[1], win_data[0]);
        else n_pass++;
        n_checks++;
        if (act_snap() !== exp_snap()) $display("FAIL load_model: got %h expected %h", act_snap(), exp_snap());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            pop = 1'b1;
            cycle();
            clear_inputs();
        end
        n_checks++;
        if (empty !== 1'b1 || act_snap() !== exp_snap())
            $display("FAIL load_drain: empty=%b snap=%h expected %h", empty, act_snap(), exp_snap());
        else n_pass++;
    endtask

    task automatic test_fill();
        do_reset();
        push(4'd3);
        push(4'd8);
        fill = 1'b1; fill_data = 4'd7; pop = 1'b1;
        cycle();
        clear_inputs();
        n_checks++;
        if (count !== 3'd4 || head_data !== 4'd7 || win_data[1] !== 4'd7 || win_data[0] !== 4'd7)
            $display("FAIL fill: count=%0d head=%h win=%h,%h required 4 7 7,7", count, head_data, win_data[1], win_data[0]);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (head_data !== 4'd7 || act_snap() !== exp_snap())
                $display("FAIL fill_slot%0d: head=%h snap=%h required 7 %h", k, head_data, act_snap(), exp_snap());
            else n_pass++;
            pop = 1'b1;
            cycle();
            clear_inputs();
        end
    endtask

    task automatic test_push_pop_empty();
        do_reset();
        in_valid = 1'b1; in_data = 4'd9; pop = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || head_data !== 4'd0)
            $display("FAIL empty_pp_same: in_ready=%b head=%h required 1 0", in_ready, head_data);
        else n_pass++;
        cycle();
        clear_inputs();
        n_checks++;
        if (count !== 3'd1 || head_data !== 4'd9 || win_valid !== 1'b0)
            $display("FAIL empty_pp_next: count=%0d head=%h wv=%b required 1 9 0", count, head_data, win_valid);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        push(4'd1);
        push(4'd2);
        push(4'd3);
        n_checks++;
        if (count !== 3'd3) $display("FAIL pre_reset_count: got %0d required 3", count);
        else n_pass++;
        in_valid = 1'b1; in_data = 4'd4;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (act_snap() !== exp_snap() || empty !== 1'b1)
            $display("FAIL async_reset: got %h expected %h", act_snap(), exp_snap());
        else n_pass++;
        clear_inputs();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 4'($urandom);
            pop       = ($urandom_range(0, 1) == 1);
            load      = ($urandom_range(0, 15) == 0);
            fill      = ($urandom_range(0, 15) == 0);
            fill_data = 4'($urandom);
            for (int i = 0; i < DEPTH; i++) load_data[i] = 4'($urandom);
            #1;
            n_checks++;
            if (in_ready !== exp_ready()) $display("FAIL rand_ready%0d: got %b expected %b", n, in_ready, exp_ready());
            else n_pass++;
            cycle();
            n_checks++;
            if (act_snap() !== exp_snap()) $display("FAIL rand_state%0d: got %h expected %h", n, act_snap(), exp_snap());
            else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_push_to_full();
        test_pop_push_wrap();
        test_load();
        test_fill();
        test_push_pop_empty();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
